trap_shaper_param: RTL
======================

TRAP_SHAPER_PARAM -- requirements
Module: trap_shaper_param

Interface
REQ-001 Parameter ADC_W, default 14, input sample width (unsigned).
REQ-002 Parameter OUT_W, default 16, output width (signed two's complement).
REQ-003 Parameter ACC_W, default 32, internal accumulator width (signed).
REQ-004 Parameter MAX_DEPTH, default 64, delay-line length in samples; DEPTH_W = clog2(MAX_DEPTH+1).
REQ-005 Parameter M_W, default 12, width of unsigned multiplier coefficient M.
REQ-006 Parameter SHIFT_W, default 5, width of output right-shift amount.
REQ-007 Parameters K_DEF=2, L_DEF=4, M_DEF=0, SHIFT_DEF=0, configuration loaded at reset.
REQ-008 clk  input  1  single clock, all logic rising-edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 in_data  input  ADC_W  ADC sample, unsigned.
REQ-011 in_valid  input  1  sample strobe; one sample accepted per high cycle.
REQ-012 cfg_load  input  1  one-cycle request to apply cfg_k/cfg_l/cfg_m/cfg_shift.
REQ-013 cfg_k, cfg_l  input  DEPTH_W each  rise time k, flat-top delay l.
REQ-014 cfg_m  input  M_W  pole-zero coefficient M; cfg_shift  input  SHIFT_W  output scaling.
REQ-015 cfg_err  output  1  registered; high one cycle after a rejected cfg_load.
REQ-016 out_data  output  OUT_W  shaped, scaled, saturated sample.
REQ-017 out_valid  output  1  high one cycle per output sample.
REQ-018 out_sat  output  1  high with out_valid when out_data was clamped.

Function
REQ-019 Per accepted sample n, with x zero-extended to ACC_W: d[n]=x[n]-x[n-k]-x[n-l]+x[n-k-l]; p[n]=p[n-1]+d[n]; r[n]=p[n]+M*d[n]; s[n]=s[n-1]+r[n]; samples before the last flush read as 0.
REQ-020 All internal arithmetic SHALL be ACC_W-bit signed, wrapping modulo 2^ACC_W without flagging.
REQ-021 out_data SHALL be s[n] arithmetically shifted right by shift, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 when clamped.
REQ-022 Delay line, accumulators and pipeline stages SHALL advance only on cycles carrying a valid sample token; gaps in in_valid SHALL NOT alter results.
REQ-023 Latency SHALL be exactly 5 cycles: in_valid at cycle N -> out_valid at N+5 with that sample's result; back-to-back in_valid gives back-to-back out_valid.
REQ-024 Accepted configuration requires 1<=cfg_k<=cfg_l and cfg_k+cfg_l<=MAX_DEPTH; otherwise cfg_load is rejected, active configuration and all state unchanged, cfg_err pulses.
REQ-025 Accepted cfg_load SHALL latch the configuration and clear delay line, p, s and all in-flight tokens on the same edge; no out_valid for samples accepted before it.
REQ-026 in_valid coincident with cfg_load (accepted or rejected) SHALL be dropped.
REQ-027 out_data SHALL hold its last value while out_valid=0.

Reset
REQ-028 reset=1 at a clock edge SHALL clear delay line, p, s, pipeline tokens, out_data, out_valid, out_sat, cfg_err to 0 and load K_DEF, L_DEF, M_DEF, SHIFT_DEF.
REQ-029 reset SHALL override cfg_load and in_valid in the same cycle; reset mid-stream SHALL suppress every pending out_valid.

Verification
REQ-030 Defaults (k=2,l=4,M=0,shift=0), impulse 1 then zeros, in_valid every cycle -> out_data 1,2,2,2,1,0,0... starting 5 cycles after impulse.
REQ-031 cfg k=2,l=4,M=1, impulse 1 -> out_data 2,3,2,2,0,-1,0...
REQ-032 Defaults, constant in_data=16383 -> out_data ramps then clamps at 32767 with out_sat=1; shift=3 reload -> settles at 16383, out_sat=0.
REQ-033 Impulse test of REQ-030 with random in_valid gaps -> identical out_data sequence, each out_valid exactly 5 cycles after its in_valid.
REQ-034 cfg_load with k=5,l=3 -> cfg_err pulse next cycle, config stays k=2,l=4, stream continues undisturbed; cfg_load with k=40,l=40 (MAX_DEPTH=64) also rejected.
REQ-035 reset asserted 2 cycles after a burst of 3 samples -> no out_valid follows, outputs 0, defaults restored.

Source files
------------

// File: rtl/trap_shaper_param.sv
// Trapezoidal pulse shaper with pole-zero correction and scaled, saturated output.
// Five-stage token pipeline; an accepted configuration reload flushes all history.
module trap_shaper_param #(
    parameter int ADC_W     = 14,
    parameter int OUT_W     = 16,
    parameter int ACC_W     = 32,
    parameter int MAX_DEPTH = 64,
    parameter int M_W       = 12,
    parameter int SHIFT_W   = 5,
    parameter int K_DEF     = 2,
    parameter int L_DEF     = 4,
    parameter int M_DEF     = 0,
    parameter int SHIFT_DEF = 0,
    localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADC_W-1:0]   in_data,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [DEPTH_W-1:0] cfg_k,
    input  logic [DEPTH_W-1:0] cfg_l,
    input  logic [M_W-1:0]     cfg_m,
    input  logic [SHIFT_W-1:0] cfg_shift,
    output logic               cfg_err,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    output logic               out_sat
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

    logic [ADC_W-1:0]   dl_q [MAX_DEPTH];
    logic [ADC_W-1:0]   dl_d [MAX_DEPTH];
    logic [DEPTH_W-1:0] k_q, k_d, l_q, l_d;
    logic [M_W-1:0]     m_q, m_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic signed [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d;
    logic signed [ACC_W-1:0] p_q, p_d, r3_q, r3_d, s_q, s_d;

    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sat_q, out_sat_d;
    logic             cfg_err_q, cfg_err_d;

    logic                    cfg_ok, flush, take;
    logic [DEPTH_W-1:0]      idx_k, idx_l, idx_kl;
    logic [ADC_W-1:0]        tap_k, tap_l, tap_kl;
    logic signed [ACC_W-1:0] d_new, m_ext, mul, shifted;

    always_comb begin
        cfg_ok = (cfg_k != '0) && (cfg_k <= cfg_l) &&
                 (({1'b0, cfg_k} + {1'b0, cfg_l}) <= (DEPTH_W + 1)'(MAX_DEPTH));
        flush  = cfg_load && cfg_ok;
        take   = in_valid && !cfg_load;

        // dl_q[0] holds the previous sample, so x[n-j] sits at index j-1
        idx_k  = k_q - 1'b1;
        idx_l  = l_q - 1'b1;
        idx_kl = k_q + l_q - 1'b1;
        tap_k  = '0;
        tap_l  = '0;
        tap_kl = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (DEPTH_W'(i) == idx_k)  tap_k  = dl_q[i];
            if (DEPTH_W'(i) == idx_l)  tap_l  = dl_q[i];
            if (DEPTH_W'(i) == idx_kl) tap_kl = dl_q[i];
        end

        d_new   = ACC_W'(in_data) - ACC_W'(tap_k) - ACC_W'(tap_l) + ACC_W'(tap_kl);
        m_ext   = ACC_W'(m_q);
        mul     = d2_q * m_ext;
        shifted = s_q >>> shift_q;
    end

    always_comb begin
        dl_d        = dl_q;
        k_d         = k_q;
        l_d         = l_q;
        m_d         = m_q;
        shift_d     = shift_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        p_d         = p_q;
        r3_d        = r3_q;
        s_d         = s_q;
        out_data_d  = out_data_q;
        out_sat_d   = 1'b0;
        cfg_err_d   = cfg_load && !cfg_ok;

        v1_d        = take;
        v2_d        = v1_q;
        v3_d        = v2_q;
        v4_d        = v3_q;
        out_valid_d = v4_q;

        if (take) begin
            for (int i = MAX_DEPTH - 1; i > 0; i--) dl_d[i] = dl_q[i-1];
            dl_d[0] = in_data;
            d1_d    = d_new;
        end
        if (v1_q) begin
            p_d  = p_q + d1_q;
            d2_d = d1_q;
        end
        if (v2_q) r3_d = p_q + mul;
        if (v3_q) s_d = s_q + r3_q;
        if (v4_q) begin
            if (shifted > SAT_MAX) begin
                out_data_d = OUT_W'(SAT_MAX);
                out_sat_d  = 1'b1;
            end else if (shifted < SAT_MIN) begin
                out_data_d = OUT_W'(SAT_MIN);
                out_sat_d  = 1'b1;
            end else begin
                out_data_d = OUT_W'(shifted);
            end
        end

        // Reload wipes history and kills every token, including the one at the output
        if (flush) begin
            k_d         = cfg_k;
            l_d         = cfg_l;
            m_d         = cfg_m;
            shift_d     = cfg_shift;
            for (int i = 0; i < MAX_DEPTH; i++) dl_d[i] = '0;
            p_d         = '0;
            s_d         = '0;
            v1_d        = 1'b0;
            v2_d        = 1'b0;
            v3_d        = 1'b0;
            v4_d        = 1'b0;
            out_valid_d = 1'b0;
            out_sat_d   = 1'b0;
            out_data_d  = out_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q        <= '{default: '0};
            k_q         <= DEPTH_W'(K_DEF);
            l_q         <= DEPTH_W'(L_DEF);
            m_q         <= M_W'(M_DEF);
            shift_q     <= SHIFT_W'(SHIFT_DEF);
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            v4_q        <= 1'b0;
            d1_q        <= '0;
            d2_q        <= '0;
            p_q         <= '0;
            r3_q        <= '0;
            s_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            dl_q        <= dl_d;
            k_q         <= k_d;
            l_q         <= l_d;
            m_q         <= m_d;
            shift_q     <= shift_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            v4_q        <= v4_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            p_q         <= p_d;
            r3_q        <= r3_d;
            s_q         <= s_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;
    assign cfg_err   = cfg_err_q;

endmodule
